// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM state and owner encodings for the memory port arbiter.
package arb_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;
  localparam int CNT_W = 8;
endpackage

// File: rtl/mux2.sv
// mux2: two-input word multiplexer; y = s ? d1 : d0.
module mux2 #(
  parameter int W = 32
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         s,
  output logic [W-1:0] y
);
  assign y = s ? d1 : d0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port between fetch and load/store.
// Ports: clk/reset (async, active high); if_* fetch requester; ls_* load/store requester;
// mem_* shared memory port; rdata mem_rdata passthrough; sel port select (0 fetch, 1 load/store);
// err one-cycle pulse when a transaction times out.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] rdata,
  output logic            sel,
  output logic            err
);
  state_t            state_q, state_d;
  owner_t            owner_q, owner_d, last_q, last_d, win;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              grant, busy, done, tmo;
  logic [XLEN-1:0]   addr_mux;
  // On a tie the requester that was not served last wins.
  assign win   = (if_req && ls_req) ? ((last_q == OWN_LS) ? OWN_IF : OWN_LS)
               : (ls_req ? OWN_LS : OWN_IF);
  // Outputs are gated by reset so they drop the moment reset rises.
  assign grant = !reset && state_q == IDLE && (if_req || ls_req);
  assign busy  = !reset && state_q == BUSY;
  assign done  = busy && mem_rvalid;
  assign tmo   = busy && !mem_rvalid && cnt_q == CNT_W'(TIMEOUT);
  // Outside a grant, sel shows the owner, which covers both BUSY and the idle hold.
  assign sel       = grant ? (win == OWN_LS) : (owner_q == OWN_LS);
  assign if_gnt    = grant && win == OWN_IF;
  assign ls_gnt    = grant && win == OWN_LS;
  assign mem_req   = grant;
  assign mem_we    = grant && sel && ls_we;
  assign mem_wdata = (grant && sel) ? ls_wdata : '0;
  assign mem_addr  = grant ? addr_mux : '0;
  assign if_rvalid = done && owner_q == OWN_IF;
  assign ls_rvalid = done && owner_q == OWN_LS;
  assign err       = tmo;
  assign rdata     = mem_rdata;
  mux2 #(.W(XLEN)) u_addr_mux (
    .d0(if_addr),
    .d1(ls_addr),
    .s (sel),
    .y (addr_mux)
  );
  always_comb begin
    state_d = grant ? BUSY : (done || tmo) ? IDLE : state_q;
    owner_d = grant ? win : owner_q;
    last_d  = (done || tmo) ? owner_q : last_q;
    cnt_d   = grant ? CNT_W'(1) : (done || tmo) ? '0 : busy ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      last_q  <= OWN_LS;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a per-cycle behavioural model and literal checks.
module tb_mem_port_arbiter;
  localparam int T = 4;
  localparam int XLEN = 32;
  logic clk = 0, reset;
  logic if_req, ls_req, ls_we, mem_rvalid;
  logic [XLEN-1:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, sel, err;
  logic [XLEN-1:0] mem_addr, mem_wdata, rdata;
  int errors = 0, checks = 0;
  bit m_busy = 0, m_owner = 0, m_last = 1;
  int m_wait = 0;

  mem_port_arbiter #(.TIMEOUT(T), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rdata(rdata),
    .sel(sel), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, g, e, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: evaluates the arbitration rules from current inputs and its own transaction state.
  always @(negedge clk) begin
    bit w;
    bit e_ig, e_lg, e_ir, e_lr, e_req, e_we, e_sel, e_err;
    logic [31:0] e_addr, e_wd;
    {e_ig, e_lg, e_ir, e_lr, e_req, e_we, e_err} = '0;
    e_addr = 0;
    e_wd = 0;
    e_sel = m_owner;
    if (reset) begin
      e_sel = 0;
      m_busy = 0; m_owner = 0; m_last = 1; m_wait = 0;
    end else if (!m_busy) begin
      if (if_req || ls_req) begin
        w = (if_req && ls_req) ? !m_last : ls_req;
        e_req = 1;
        e_sel = w;
        e_ig = !w;
        e_lg = w;
        e_addr = w ? ls_addr : if_addr;
        e_wd = w ? ls_wdata : 0;
        e_we = w && ls_we;
        m_busy = 1; m_owner = w; m_wait = 1;
      end
    end else if (mem_rvalid) begin
      e_ir = !m_owner;
      e_lr = m_owner;
      m_last = m_owner; m_busy = 0;
    end else if (m_wait == T) begin
      e_err = 1;
      m_last = m_owner; m_busy = 0;
    end else m_wait++;
    chk("m_if_gnt", if_gnt, e_ig);
    chk("m_ls_gnt", ls_gnt, e_lg);
    chk("m_if_rvalid", if_rvalid, e_ir);
    chk("m_ls_rvalid", ls_rvalid, e_lr);
    chk("m_mem_req", mem_req, e_req);
    chk("m_mem_we", mem_we, e_we);
    chk("m_sel", sel, e_sel);
    chk("m_err", err, e_err);
    chk("m_mem_addr", mem_addr, e_addr);
    chk("m_mem_wdata", mem_wdata, e_wd);
    chk("m_rdata", rdata, mem_rdata);
  end

  initial begin
    reset = 1; if_req = 1; ls_req = 1; ls_we = 1; mem_rvalid = 0;
    if_addr = 'h11; ls_addr = 'h22; ls_wdata = 'h33; mem_rdata = 'h5A5A;
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_sel", sel, 0);
    chk("rst_rdata", rdata, 'h5A5A);
    cyc(); reset = 0; if_req = 0; ls_req = 0; ls_we = 0; if_addr = 0; ls_addr = 0; ls_wdata = 0;
    // single fetch, response three cycles after grant
    cyc(); if_req = 1; if_addr = 'h100;
    @(negedge clk);
    chk("f_gnt", if_gnt, 1);
    chk("f_mem_req", mem_req, 1);
    chk("f_sel", sel, 0);
    chk("f_addr", mem_addr, 'h100);
    cyc(); if_req = 0; if_addr = 0;
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      chk("f_wait_rvalid", if_rvalid, 0);
      cyc();
    end
    mem_rvalid = 1; mem_rdata = 'h1234;
    @(negedge clk);
    chk("f_rvalid", if_rvalid, 1);
    chk("f_rdata", rdata, 'h1234);
    cyc(); mem_rvalid = 0;
    @(negedge clk);
    chk("f_idle_req", mem_req, 0);
    // both requesters held from reset: IF, LS, IF, LS
    cyc(); reset = 1;
    cyc(); reset = 0; if_req = 1; ls_req = 1; if_addr = 'h10; ls_addr = 'h20;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_if_gnt", if_gnt, k % 2 == 0);
      chk("rr_ls_gnt", ls_gnt, k % 2 == 1);
      chk("rr_sel", sel, k % 2 == 1);
      cyc(); mem_rvalid = 1;
      @(negedge clk);
      chk("rr_bubble", mem_req, 0);
      chk("rr_if_rvalid", if_rvalid, k % 2 == 0);
      cyc(); mem_rvalid = 0;
    end
    if_req = 0; ls_req = 0; if_addr = 0; ls_addr = 0;
    // store
    cyc(); ls_req = 1; ls_we = 1; ls_addr = 'h200; ls_wdata = 'hDEADBEEF;
    @(negedge clk);
    chk("st_gnt", ls_gnt, 1);
    chk("st_we", mem_we, 1);
    chk("st_wdata", mem_wdata, 'hDEADBEEF);
    chk("st_addr", mem_addr, 'h200);
    chk("st_sel", sel, 1);
    cyc(); ls_req = 0; ls_we = 0;
    cyc(); mem_rvalid = 1;
    @(negedge clk);
    chk("st_ack", ls_rvalid, 1);
    cyc(); mem_rvalid = 0;
    @(negedge clk);
    chk("st_sel_hold", sel, 1);
    // stray response while idle
    cyc(); mem_rvalid = 1;
    @(negedge clk);
    chk("stray_rvalid", ls_rvalid, 0);
    chk("stray_err", err, 0);
    cyc(); mem_rvalid = 0;
    // timeout
    if_req = 1; if_addr = 'h300;
    @(negedge clk);
    chk("to_gnt", if_gnt, 1);
    cyc(); if_req = 0;
    for (int i = 1; i <= T; i++) begin
      @(negedge clk);
      chk("to_err", err, i == T);
      chk("to_rvalid", if_rvalid, 0);
      cyc();
    end
    if_req = 1;
    @(negedge clk);
    chk("to_regrant", if_gnt, 1);
    cyc(); if_req = 0;
    // response in the timeout cycle wins
    for (int i = 1; i <= T; i++) begin
      mem_rvalid = (i == T);
      @(negedge clk);
      if (i == T) begin
        chk("tie_rvalid", if_rvalid, 1);
        chk("tie_err", err, 0);
      end
      cyc();
    end
    mem_rvalid = 0;
    // reset mid-transaction, then a late response
    ls_req = 1; ls_addr = 'h400;
    @(negedge clk);
    chk("rb_gnt", ls_gnt, 1);
    cyc(); reset = 1;
    @(negedge clk);
    chk("rb_gnt_low", ls_gnt, 0);
    chk("rb_req_low", mem_req, 0);
    chk("rb_sel", sel, 0);
    chk("rb_err", err, 0);
    cyc(); reset = 0; ls_req = 0; mem_rvalid = 1;
    @(negedge clk);
    chk("rb_late_rvalid", ls_rvalid, 0);
    chk("rb_late_err", err, 0);
    cyc(); mem_rvalid = 0;
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
